// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - SPI master byte shift engine with configurable mode and divider
module spi_shift_engine #(
  parameter int CPOL    = 0,
  parameter int CPHA    = 0,
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       ready,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs_n
);

  localparam int               DIV_W     = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic             IDLE_CLK  = (CPOL != 0);
  // CPHA=1 samples MISO on even edges and launches MOSI on odd edges
  localparam logic             LATE_PHASE = (CPHA != 0);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] div_cnt, div_n;
  logic [4:0]       edge_cnt, edge_n;
  logic [7:0]       tx_sh, tx_sh_n;
  logic [7:0]       rx_sh, rx_sh_n;
  logic [7:0]       rx_data_n;
  logic             busy_n, ready_n, spi_clk_n, spi_mosi_n, spi_cs_n_n;
  logic             odd_edge, do_sample, do_advance;

  // Register every piece of state and every output; reset forces the idle bus levels
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      busy     <= 1'b0;
      ready    <= 1'b0;
      spi_clk  <= IDLE_CLK;
      spi_mosi <= 1'b1;
      spi_cs_n <= 1'b1;
    end else begin
      state    <= state_n;
      div_cnt  <= div_n;
      edge_cnt <= edge_n;
      tx_sh    <= tx_sh_n;
      rx_sh    <= rx_sh_n;
      rx_data  <= rx_data_n;
      busy     <= busy_n;
      ready    <= ready_n;
      spi_clk  <= spi_clk_n;
      spi_mosi <= spi_mosi_n;
      spi_cs_n <= spi_cs_n_n;
    end
  end

  // Next-state and next-output decode; edge_cnt counts edges already issued, so the
  // edge being issued now is odd when edge_cnt is even
  always_comb begin
    state_n    = state;
    div_n      = div_cnt;
    edge_n     = edge_cnt;
    tx_sh_n    = tx_sh;
    rx_sh_n    = rx_sh;
    rx_data_n  = rx_data;
    busy_n     = busy;
    ready_n    = ready;
    spi_clk_n  = spi_clk;
    spi_mosi_n = spi_mosi;
    spi_cs_n_n = spi_cs_n;
    odd_edge   = ~edge_cnt[0];
    do_sample  = odd_edge ^ LATE_PHASE;
    do_advance = LATE_PHASE ? odd_edge : (~odd_edge && (edge_cnt != 5'd15));
    case (state)
      IDLE: begin
        if (start) begin
          state_n    = LEAD;
          div_n      = '0;
          edge_n     = '0;
          rx_sh_n    = '0;
          busy_n     = 1'b1;
          ready_n    = 1'b0;
          spi_cs_n_n = 1'b0;
          // CPHA=0 presents bit 7 before the first edge; CPHA=1 launches it on edge 1
          if (LATE_PHASE) begin
            tx_sh_n    = tx_data;
            spi_mosi_n = 1'b1;
          end else begin
            tx_sh_n    = {tx_data[6:0], 1'b0};
            spi_mosi_n = tx_data[7];
          end
        end
      end
      LEAD: begin
        if (div_cnt == DIV_LAST) begin
          div_n   = '0;
          state_n = SHIFT;
        end else begin
          div_n = div_cnt + DIV_W'(1);
        end
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_n     = '0;
          spi_clk_n = ~spi_clk;
          edge_n    = edge_cnt + 5'd1;
          if (do_sample) begin
            rx_sh_n = {rx_sh[6:0], spi_miso};
          end
          if (do_advance) begin
            spi_mosi_n = tx_sh[7];
            tx_sh_n    = {tx_sh[6:0], 1'b0};
          end
          if (edge_cnt == 5'd15) begin
            state_n = TRAIL;
          end
        end else begin
          div_n = div_cnt + DIV_W'(1);
        end
      end
      TRAIL: begin
        if (div_cnt == DIV_LAST) begin
          div_n      = '0;
          state_n    = IDLE;
          rx_data_n  = rx_sh;
          ready_n    = 1'b1;
          busy_n     = 1'b0;
          spi_cs_n_n = 1'b1;
          spi_mosi_n = 1'b1;
          spi_clk_n  = IDLE_CLK;
        end else begin
          div_n = div_cnt + DIV_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// tb/tb_spi_shift_engine.sv - randomized self-checking bench for spi_shift_engine
module tb_spi_shift_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] start = 3'b000;
  logic [7:0] tx_data [3];
  wire  [7:0] rx_data [3];
  wire  [2:0] busy, ready, sclk, mosi, csn;
  logic       slave_miso = 1'b1;
  logic [7:0] sl_tx = 8'h00;
  logic [7:0] sl_rx = 8'h00;
  int         sl_edges = 0;
  logic       sl_prev = 1'b1;
  logic [2:0] cpol_of = 3'b010;
  int         checks = 0;
  int         errors = 0;

  // Instance 0: mode 0, divide-by-2, loopback
  spi_shift_engine #(.CPOL(0), .CPHA(0), .CLK_DIV(2)) u_m0 (
    .clk(clk), .rst(rst), .start(start[0]), .tx_data(tx_data[0]), .rx_data(rx_data[0]),
    .busy(busy[0]), .ready(ready[0]), .spi_clk(sclk[0]), .spi_mosi(mosi[0]),
    .spi_miso(mosi[0]), .spi_cs_n(csn[0]));

  // Instance 1: mode 3, divide-by-3, external slave model
  spi_shift_engine #(.CPOL(1), .CPHA(1), .CLK_DIV(3)) u_m1 (
    .clk(clk), .rst(rst), .start(start[1]), .tx_data(tx_data[1]), .rx_data(rx_data[1]),
    .busy(busy[1]), .ready(ready[1]), .spi_clk(sclk[1]), .spi_mosi(mosi[1]),
    .spi_miso(slave_miso), .spi_cs_n(csn[1]));

  // Instance 2: mode 0, divide-by-1, loopback
  spi_shift_engine #(.CPOL(0), .CPHA(0), .CLK_DIV(1)) u_m2 (
    .clk(clk), .rst(rst), .start(start[2]), .tx_data(tx_data[2]), .rx_data(rx_data[2]),
    .busy(busy[2]), .ready(ready[2]), .spi_clk(sclk[2]), .spi_mosi(mosi[2]),
    .spi_miso(mosi[2]), .spi_cs_n(csn[2]));

  // Mode-3 slave: drives its byte MSB first after odd edges, captures MOSI after even edges
  always @(negedge clk) begin
    if (csn[1]) begin
      sl_edges = 0;
    end else if (sclk[1] != sl_prev) begin
      sl_edges = sl_edges + 1;
      if (sl_edges % 2 == 1) slave_miso = sl_tx[7 - sl_edges / 2];
      else sl_rx = {sl_rx[6:0], mosi[1]};
    end
    sl_prev = sclk[1];
  end

  // Global time bound so the run can never hang
  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  // Issue one start and measure the transfer from the outside at negedges
  task automatic xfer(input int i, input logic [7:0] tx, input int hold_at,
                      output int bcyc, output int rises, output int rdy_hi, output logic lead_mosi);
    logic prev;
    tx_data[i] = tx;
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    bcyc = 0; rises = 0; rdy_hi = 0;
    prev = sclk[i];
    lead_mosi = mosi[i];
    while (busy[i] === 1'b1 && bcyc < 1000) begin
      bcyc++;
      if (!prev && sclk[i]) rises++;
      if (ready[i] !== 1'b0) rdy_hi++;
      if (bcyc == hold_at) start[i] = 1'b1;
      prev = sclk[i];
      @(negedge clk);
    end
    if (!prev && sclk[i]) rises++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++; if (busy[i] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d] got %b exp 0", i, busy[i]); end
      checks++; if (ready[i] !== 1'b0) begin errors++; $display("FAIL reset_ready[%0d] got %b exp 0", i, ready[i]); end
      checks++; if (rx_data[i] !== 8'h00) begin errors++; $display("FAIL reset_rx[%0d] got %h exp 00", i, rx_data[i]); end
      checks++; if (csn[i] !== 1'b1) begin errors++; $display("FAIL reset_csn[%0d] got %b exp 1", i, csn[i]); end
      checks++; if (mosi[i] !== 1'b1) begin errors++; $display("FAIL reset_mosi[%0d] got %b exp 1", i, mosi[i]); end
      checks++; if (sclk[i] !== cpol_of[i]) begin errors++; $display("FAIL reset_sclk[%0d] got %b exp %b", i, sclk[i], cpol_of[i]); end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_loopback();
    int b, r, h; logic lm; logic [7:0] tx;
    xfer(0, 8'hA5, -1, b, r, h, lm);
    checks++; if (b != 36) begin errors++; $display("FAIL lb_busy_len got %0d exp 36", b); end
    checks++; if (rx_data[0] !== 8'hA5) begin errors++; $display("FAIL lb_rx got %h exp a5", rx_data[0]); end
    checks++; if (ready[0] !== 1'b1) begin errors++; $display("FAIL lb_ready got %b exp 1", ready[0]); end
    checks++; if (csn[0] !== 1'b1) begin errors++; $display("FAIL lb_csn got %b exp 1", csn[0]); end
    checks++; if (r != 8) begin errors++; $display("FAIL lb_rises got %0d exp 8", r); end
    checks++; if (h != 0) begin errors++; $display("FAIL lb_ready_during_busy got %0d exp 0", h); end
    checks++; if (lm !== 1'b1) begin errors++; $display("FAIL lb_lead_mosi got %b exp 1", lm); end
    for (int k = 0; k < 4; k++) begin
      tx = 8'($urandom);
      xfer(0, tx, -1, b, r, h, lm);
      checks++; if (rx_data[0] !== tx || b != 36 || lm !== tx[7])
        begin errors++; $display("FAIL lb_rand rx %h exp %h busy %0d exp 36 lead %b exp %b", rx_data[0], tx, b, lm, tx[7]); end
    end
  endtask

  task automatic test_slave();
    int b, r, h; logic lm; logic [7:0] tx, st;
    checks++; if (sclk[1] !== 1'b1) begin errors++; $display("FAIL sl_idle_before got %b exp 1", sclk[1]); end
    sl_tx = 8'h3C;
    xfer(1, 8'hC3, -1, b, r, h, lm);
    checks++; if (sl_rx !== 8'hC3) begin errors++; $display("FAIL sl_slave_rx got %h exp c3", sl_rx); end
    checks++; if (rx_data[1] !== 8'h3C) begin errors++; $display("FAIL sl_master_rx got %h exp 3c", rx_data[1]); end
    checks++; if (b != 54) begin errors++; $display("FAIL sl_busy_len got %0d exp 54", b); end
    checks++; if (sclk[1] !== 1'b1) begin errors++; $display("FAIL sl_idle_after got %b exp 1", sclk[1]); end
    checks++; if (r != 8) begin errors++; $display("FAIL sl_rises got %0d exp 8", r); end
    for (int k = 0; k < 4; k++) begin
      tx = 8'($urandom); st = 8'($urandom);
      sl_tx = st;
      xfer(1, tx, -1, b, r, h, lm);
      checks++; if (sl_rx !== tx || rx_data[1] !== st || b != 54)
        begin errors++; $display("FAIL sl_rand slave %h exp %h master %h exp %h busy %0d exp 54", sl_rx, tx, rx_data[1], st, b); end
    end
  endtask

  task automatic test_start_held();
    int b, accepts; logic pb;
    b = 0; accepts = 0; pb = busy[0];
    tx_data[0] = 8'h5A;
    start[0] = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == 0) tx_data[0] = 8'hFF;
      if (k == 9) start[0] = 1'b0;
      if (busy[0]) b++;
      if (busy[0] && !pb) accepts++;
      pb = busy[0];
    end
    checks++; if (accepts != 1) begin errors++; $display("FAIL held_accepts got %0d exp 1", accepts); end
    checks++; if (b != 36) begin errors++; $display("FAIL held_busy_len got %0d exp 36", b); end
    checks++; if (rx_data[0] !== 8'h5A) begin errors++; $display("FAIL held_rx got %h exp 5a", rx_data[0]); end
  endtask

  task automatic test_reset_mid();
    int b, r, h; logic lm; logic [7:0] tx;
    tx_data[0] = 8'($urandom);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL rmid_busy_before got %b exp 1", busy[0]); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy[0]); end
    checks++; if (ready[0] !== 1'b0) begin errors++; $display("FAIL rmid_ready got %b exp 0", ready[0]); end
    checks++; if (rx_data[0] !== 8'h00) begin errors++; $display("FAIL rmid_rx got %h exp 00", rx_data[0]); end
    checks++; if (csn[0] !== 1'b1) begin errors++; $display("FAIL rmid_csn got %b exp 1", csn[0]); end
    checks++; if (sclk[0] !== 1'b0) begin errors++; $display("FAIL rmid_sclk got %b exp 0", sclk[0]); end
    @(negedge clk);
    tx = 8'($urandom);
    xfer(0, tx, -1, b, r, h, lm);
    checks++; if (rx_data[0] !== tx || b != 36 || ready[0] !== 1'b1)
      begin errors++; $display("FAIL rmid_after rx %h exp %h busy %0d exp 36 ready %b exp 1", rx_data[0], tx, b, ready[0]); end
  endtask

  task automatic test_back_to_back();
    int b, r, h; logic lm;
    xfer(2, 8'h01, 18, b, r, h, lm);
    checks++; if (b != 18) begin errors++; $display("FAIL b2b_first_len got %0d exp 18", b); end
    checks++; if (rx_data[2] !== 8'h01) begin errors++; $display("FAIL b2b_first_rx got %h exp 01", rx_data[2]); end
    checks++; if (busy[2] !== 1'b0) begin errors++; $display("FAIL b2b_start_at_ready_ignored busy %b exp 0", busy[2]); end
    checks++; if (ready[2] !== 1'b1) begin errors++; $display("FAIL b2b_first_ready got %b exp 1", ready[2]); end
    xfer(2, 8'h80, -1, b, r, h, lm);
    checks++; if (b != 18) begin errors++; $display("FAIL b2b_second_len got %0d exp 18", b); end
    checks++; if (h != 0) begin errors++; $display("FAIL b2b_ready_low got %0d high cycles exp 0", h); end
    checks++; if (rx_data[2] !== 8'h80) begin errors++; $display("FAIL b2b_second_rx got %h exp 80", rx_data[2]); end
    checks++; if (ready[2] !== 1'b1) begin errors++; $display("FAIL b2b_second_ready got %b exp 1", ready[2]); end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) tx_data[i] = 8'h00;
    test_reset();
    test_loopback();
    test_slave();
    test_start_held();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
